// File: rtl/dp1_sweep_ctrl.sv
// Sweep sequencer for the DP1 3-in/3-out logic unit: steps {a,b,c} through all
// eight vectors, samples {x,y,z} after a settle window and reports the results.
module dp1_sweep_ctrl #(
  parameter int HOLD_CYCLES = 2,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       x_in,
  input  logic       y_in,
  input  logic       z_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_seen,
  output logic [2:0] first_fail,
  output logic [2:0] fail_bits
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_count_q, err_count_d;
  logic       fail_seen_q, fail_seen_d;
  logic [2:0] first_fail_q, first_fail_d;
  logic [2:0] fail_bits_q, fail_bits_d;

  logic       sample_edge;
  logic       last_vec;
  logic [2:0] mm;
  logic [3:0] err_next;

  // DP1 reference truth table, {x,y,z} indexed by {a,b,c}.
  function automatic logic [2:0] dp1_expected(input logic [2:0] v);
    case (v)
      3'd0:    dp1_expected = 3'b010;
      3'd1:    dp1_expected = 3'b101;
      3'd2:    dp1_expected = 3'b010;
      3'd3:    dp1_expected = 3'b100;
      3'd4:    dp1_expected = 3'b011;
      3'd5:    dp1_expected = 3'b001;
      3'd6:    dp1_expected = 3'b000;
      default: dp1_expected = 3'b001;
    endcase
  endfunction

  assign sample_edge = (state_q == APPLY) && (cnt_q == HOLD_LAST);
  assign last_vec    = (idx_q == 3'd7);
  assign mm          = {x_in, y_in, z_in} ^ dp1_expected(idx_q);
  assign err_next    = (|mm) ? err_count_q + 4'd1 : err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 4'd0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= 3'd0;
      fail_bits_q  <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
      fail_bits_q  <= fail_bits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY:      if (sample_edge && last_vec) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_count_d  = err_count_q;
    fail_seen_d  = fail_seen_q;
    first_fail_d = first_fail_q;
    fail_bits_d  = fail_bits_q;
    if (state_q == APPLY) begin
      cnt_d = cnt_q + CW'(1);
      if (sample_edge) begin
        err_count_d = err_next;
        if ((|mm) && !fail_seen_q) begin
          first_fail_d = idx_q;
          fail_bits_d  = mm;
          fail_seen_d  = 1'b1;
        end
        cnt_d = '0;
        if (last_vec) begin
          // {a,b,c} return to 000 once the sweep is over.
          idx_d  = 3'd0;
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_next == 4'd0);
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end else if (start) begin
      idx_d        = 3'd0;
      cnt_d        = '0;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      err_count_d  = 4'd0;
      fail_seen_d  = 1'b0;
      first_fail_d = 3'd0;
      fail_bits_d  = 3'd0;
    end
  end

  assign a          = idx_q[2];
  assign b          = idx_q[1];
  assign c          = idx_q[0];
  assign vec_idx    = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_seen  = fail_seen_q;
  assign first_fail = first_fail_q;
  assign fail_bits  = fail_bits_q;

endmodule

// File: tb/tb_dp1_sweep_ctrl.sv
// Bench for dp1_sweep_ctrl: a DP1 model with selectable faults feeds the main
// instance; two extra instances cover the short and long settle builds.
module tb_dp1_sweep_ctrl;

  localparam int H = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;
  int   fault = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // DP1 reference as sum-of-products equations, {x,y,z}.
  function automatic logic [2:0] golden(input logic [2:0] v);
    logic aa, bb, cc;
    {aa, bb, cc} = v;
    golden = {~aa & cc, (~cc & ~bb) | (~cc & ~aa), (~bb & cc) | (aa & cc) | (aa & ~bb)};
  endfunction

  logic a, b, c, busy, done, pass, fail_seen, x_in, y_in, z_in;
  logic [2:0] vec_idx, first_fail, fail_bits;
  logic [3:0] err_count;
  logic [2:0] g, r;

  always_comb begin
    g = golden({a, b, c});
    r = g;
    case (fault)
      1: r = {g[2], g[1], 1'b0};   // z stuck at 0
      2: r = {g[1], g[2], g[0]};   // x and y swapped
      3: r = ~g;                   // every output inverted
      4: r = {g[2], 1'b0, g[0]};   // y stuck at 0
      default: r = g;
    endcase
  end
  assign {x_in, y_in, z_in} = r;

  dp1_sweep_ctrl #(.HOLD_CYCLES(H), .CW(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .a(a), .b(b), .c(c), .vec_idx(vec_idx), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_seen(fail_seen), .first_fail(first_fail), .fail_bits(fail_bits)
  );

  logic a1, b1, c1, busy1, done1, pass1, seen1;
  logic [2:0] idx1, ff1, fb1, r1;
  logic [3:0] err1;
  assign r1 = golden({a1, b1, c1});

  dp1_sweep_ctrl #(.HOLD_CYCLES(1), .CW(2)) dut_h1 (
    .clk(clk), .reset(reset), .start(start_s),
    .x_in(r1[2]), .y_in(r1[1]), .z_in(r1[0]),
    .a(a1), .b(b1), .c(c1), .vec_idx(idx1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_seen(seen1), .first_fail(ff1), .fail_bits(fb1)
  );

  logic a5, b5, c5, busy5, done5, pass5, seen5;
  logic [2:0] idx5, ff5, fb5, r5;
  logic [3:0] err5;
  assign r5 = golden({a5, b5, c5});

  dp1_sweep_ctrl #(.HOLD_CYCLES(5), .CW(4)) dut_h5 (
    .clk(clk), .reset(reset), .start(start_s),
    .x_in(r5[2]), .y_in(r5[1]), .z_in(r5[0]),
    .a(a5), .b(b5), .c(c5), .vec_idx(idx5), .busy(busy5), .done(done5), .pass(pass5),
    .err_count(err5), .fail_seen(seen5), .first_fail(ff5), .fail_bits(fb5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] all_outs();
    return {a, b, c, vec_idx, busy, done, pass, err_count, fail_seen, first_fail, fail_bits};
  endfunction

  typedef struct {
    int         mode;
    int         restart_at;
    logic [3:0] err;
    logic       pass;
    logic       seen;
    logic [2:0] ff;
    logic [2:0] fb;
  } vec_t;

  vec_t tbl[6];

  // One sweep on the main instance; restart_at > 0 pulses start so it is sampled at that edge.
  task automatic run_sweep(input vec_t v);
    int lat, step_bad;
    fault = v.mode;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_clear", {vec_idx, busy, done, pass, err_count, fail_seen},
          {3'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
    lat = -1;
    step_bad = 0;
    for (int k = 1; k <= 8 * H + 4 && lat < 0; k++) begin
      if (k == v.restart_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (done) lat = k;
      else if (vec_idx !== 3'(k / H) || {a, b, c} !== vec_idx || busy !== 1'b1) step_bad++;
    end
    check("done_latency", lat, 8 * H);
    check("vector_steps", step_bad, 0);
    check("end_abc_busy", {a, b, c, busy}, 4'b0000);
    check("err_count", err_count, v.err);
    check("pass", pass, v.pass);
    check("fail_seen", fail_seen, v.seen);
    check("first_fail", first_fail, v.ff);
    check("fail_bits", fail_bits, v.fb);
  endtask

  initial begin
    int n1, n5;
    tbl[0] = '{0, -1, 4'd0, 1'b1, 1'b0, 3'd0, 3'b000};
    tbl[1] = '{1, -1, 4'd4, 1'b0, 1'b1, 3'd1, 3'b001};
    tbl[2] = '{2, -1, 4'd5, 1'b0, 1'b1, 3'd0, 3'b110};
    tbl[3] = '{1,  5, 4'd4, 1'b0, 1'b1, 3'd1, 3'b001};
    tbl[4] = '{3, -1, 4'd8, 1'b0, 1'b1, 3'd0, 3'b111};
    tbl[5] = '{4, -1, 4'd3, 1'b0, 1'b1, 3'd0, 3'b010};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_outputs", all_outs(), 20'd0);
    repeat (2) @(posedge clk);
    #1 check("idle_hold", all_outs(), 20'd0);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // Reset in the middle of a sweep, after two mismatches have been counted.
    fault = 4;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40 && vec_idx !== 3'd3; k++) begin
      @(posedge clk); #1;
    end
    check("mid_idx", vec_idx, 3'd3);
    check("mid_err", err_count, 4'd2);
    @(negedge clk) begin
      reset = 1'b1;
      start = 1'b1;
    end
    @(posedge clk); #1;
    check("mid_reset_outputs", all_outs(), 20'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", all_outs(), 20'd0);
    run_sweep(tbl[0]);

    // Short and long settle builds run side by side.
    n1 = 0;
    n5 = 0;
    @(negedge clk) start_s = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1 start_s = 1'b0;
      if (busy1) n1++;
      if (busy5) n5++;
    end
    check("h1_busy_cycles", n1, 8);
    check("h5_busy_cycles", n5, 40);
    check("h1_result", {done1, pass1, err1, seen1}, {1'b1, 1'b1, 4'd0, 1'b0});
    check("h5_result", {done5, pass5, err5, seen5}, {1'b1, 1'b1, 4'd0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
